// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for its data-SRAM response,
// extracts load data and forwards a result bus to WB; drops orphaned responses after a flush.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        es_to_ms_valid,
  input  logic [76:0] es_to_ms_bus,
  output logic        ms_allowin,
  input  logic        ws_allowin,
  output logic        ms_to_ws_valid,
  output logic [72:0] ms_to_ws_bus,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        ws_ex,
  input  logic        ws_eret,
  output logic [4:0]  MEM_dest,
  output logic [31:0] MEM_dest_data,
  output logic        MEM_load_stall,
  output logic        MS_EX
);

  localparam int unsigned ES_W  = 77;
  localparam int unsigned CNT_W = 2;

  localparam logic [2:0] OP_LW  = 3'd1;
  localparam logic [2:0] OP_LB  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_LH  = 3'd4;
  localparam logic [2:0] OP_LHU = 3'd5;

  logic             ms_valid_q, ms_valid_d;
  logic [ES_W-1:0]  bus_q, bus_d;
  logic             buf_valid_q, buf_valid_d;
  logic [31:0]      buf_data_q, buf_data_d;
  logic [CNT_W-1:0] discard_cnt_q, discard_cnt_d;

  logic        eret, bd, ex, mem_req, gr_we;
  logic [2:0]  mem_op;
  logic [4:0]  dest;
  logic [31:0] alu_result, pc;
  logic [1:0]  off;

  logic        flush, wait_req, resp_now, have_data, ms_ready_go, ms_leave;
  logic        cnt_inc, cnt_dec;
  logic [31:0] rdata_sel, final_result;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign {eret, bd, ex, mem_op, mem_req, gr_we, dest, alu_result, pc} = bus_q;
  assign off = alu_result[1:0];

  // Handshake and response bookkeeping
  always_comb begin
    flush          = ws_ex | ws_eret;
    wait_req       = ms_valid_q & mem_req & ~ex;
    resp_now       = data_sram_data_ok & (discard_cnt_q == '0);
    have_data      = resp_now | buf_valid_q;
    rdata_sel      = buf_valid_q ? buf_data_q : data_sram_rdata;
    ms_ready_go    = ~wait_req | have_data;
    ms_to_ws_valid = ms_valid_q & ms_ready_go;
    ms_allowin     = ~ms_valid_q | (ms_ready_go & ws_allowin);
    ms_leave       = ms_to_ws_valid & ws_allowin;
    cnt_inc        = flush & wait_req & ~have_data;
    cnt_dec        = data_sram_data_ok & (discard_cnt_q != '0);
  end

  // Load data extraction
  always_comb begin
    byte_sel     = rdata_sel[{off, 3'b000} +: 8];
    half_sel     = off[1] ? rdata_sel[31:16] : rdata_sel[15:0];
    final_result = alu_result;
    case (mem_op)
      OP_LW:   final_result = rdata_sel;
      OP_LB:   final_result = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  final_result = {24'h0, byte_sel};
      OP_LH:   final_result = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  final_result = {16'h0, half_sel};
      default: final_result = alu_result;
    endcase
  end

  assign ms_to_ws_bus   = {eret, bd, ex, gr_we, dest, final_result, pc};
  assign MEM_dest       = dest & {5{ms_valid_q & gr_we}};
  assign MEM_dest_data  = final_result;
  assign MEM_load_stall = wait_req & gr_we & ~have_data;
  assign MS_EX          = ms_valid_q & (ex | eret);

  // Next-state: flush wins over loading; orphan responses are counted for discard
  always_comb begin
    ms_valid_d    = ms_valid_q;
    bus_d         = bus_q;
    buf_valid_d   = buf_valid_q;
    buf_data_d    = buf_data_q;
    discard_cnt_d = discard_cnt_q;

    if (flush) begin
      ms_valid_d  = 1'b0;
      bus_d       = '0;
      buf_valid_d = 1'b0;
    end else begin
      if (ms_allowin) ms_valid_d = es_to_ms_valid;
      if (es_to_ms_valid & ms_allowin) bus_d = es_to_ms_bus;
      if (ms_leave) begin
        buf_valid_d = 1'b0;
      end else if (resp_now & wait_req & ~buf_valid_q) begin
        buf_valid_d = 1'b1;
        buf_data_d  = data_sram_rdata;
      end
    end

    if (cnt_inc && !cnt_dec && discard_cnt_q != '1) begin
      discard_cnt_d = discard_cnt_q + CNT_W'(1);
    end else if (cnt_dec && !cnt_inc) begin
      discard_cnt_d = discard_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q    <= 1'b0;
      bus_q         <= '0;
      buf_valid_q   <= 1'b0;
      buf_data_q    <= '0;
      discard_cnt_q <= '0;
    end else begin
      ms_valid_q    <= ms_valid_d;
      bus_q         <= bus_d;
      buf_valid_q   <= buf_valid_d;
      buf_data_q    <= buf_data_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios followed by randomized single-instruction traffic.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        es_to_ms_valid;
  logic [76:0] es_to_ms_bus;
  logic        ms_allowin;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [72:0] ms_to_ws_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ws_ex;
  logic        ws_eret;
  logic [4:0]  MEM_dest;
  logic [31:0] MEM_dest_data;
  logic        MEM_load_stall;
  logic        MS_EX;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus), .ms_allowin(ms_allowin),
    .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .ws_ex(ws_ex), .ws_eret(ws_eret),
    .MEM_dest(MEM_dest), .MEM_dest_data(MEM_dest_data),
    .MEM_load_stall(MEM_load_stall), .MS_EX(MS_EX)
  );

  task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [76:0] es_bus(input logic eret, input logic bd, input logic ex,
                                         input logic [2:0] op, input logic req, input logic we,
                                         input logic [4:0] dest, input logic [31:0] alu,
                                         input logic [31:0] pc);
    return {eret, bd, ex, op, req, we, dest, alu, pc};
  endfunction

  function automatic logic [72:0] ws_bus(input logic eret, input logic bd, input logic ex,
                                         input logic we, input logic [4:0] dest,
                                         input logic [31:0] res, input logic [31:0] pc);
    return {eret, bd, ex, we, dest, res, pc};
  endfunction

  // Reference result from the load rules, using plain shifts and arithmetic
  function automatic logic [31:0] ref_result(input int op, input logic [31:0] alu,
                                             input logic [31:0] rd);
    int unsigned off, b, h;
    off = alu % 4;
    b   = (rd >> (8 * off)) % 256;
    h   = (rd >> (16 * (off / 2))) % 65536;
    case (op)
      1: return rd;
      2: return (b >= 128) ? 32'(b + 32'hFFFF_FF00) : 32'(b);
      3: return 32'(b);
      4: return (h >= 32768) ? 32'(h + 32'hFFFF_0000) : 32'(h);
      5: return 32'(h);
      default: return alu;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic issue(input logic [76:0] b);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = b;
    tick();
    es_to_ms_valid = 1'b0;
    es_to_ms_bus   = '0;
  endtask

  task automatic load_case(input string tag, input logic [2:0] op, input logic [1:0] off,
                           input logic [31:0] exp);
    logic [31:0] addr;
    addr = 32'h1000_0000 | 32'(off);
    issue(es_bus(1'b0, 1'b0, 1'b0, op, 1'b1, 1'b1, 5'd9, addr, 32'hBFC0_0100));
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80FF_7F01;
    settle();
    chk({tag, "_valid"}, 73'(ms_to_ws_valid), 73'(1'b1));
    chk(tag, ms_to_ws_bus, ws_bus(1'b0, 1'b0, 1'b0, 1'b1, 5'd9, exp, 32'hBFC0_0100));
    tick();
    data_sram_data_ok = 1'b0;
  endtask

  initial begin
    logic [72:0] exp_bus;
    reset = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0; ws_allowin = 1'b1;
    data_sram_data_ok = 1'b0; data_sram_rdata = '0; ws_ex = 1'b0; ws_eret = 1'b0;
    tick(); tick();
    reset = 1'b0;
    settle();
    chk("rst_valid", 73'(ms_to_ws_valid), 73'(1'b0));
    chk("rst_allowin", 73'(ms_allowin), 73'(1'b1));
    chk("rst_bus", ms_to_ws_bus, '0);
    chk("rst_dest", 73'(MEM_dest), '0);
    chk("rst_stall", 73'(MEM_load_stall), '0);
    chk("rst_msex", 73'(MS_EX), '0);

    // ALU pass-through
    issue(es_bus(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 32'hBFC0_0000));
    settle();
    chk("alu_valid", 73'(ms_to_ws_valid), 73'(1'b1));
    chk("alu_bus", ms_to_ws_bus, ws_bus(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'hBFC0_0000));
    chk("alu_memdest", 73'(MEM_dest), 73'(5'd5));
    chk("alu_fwd", 73'(MEM_dest_data), 73'(32'h1234));
    tick();
    settle();
    chk("alu_gone", 73'(ms_to_ws_valid), 73'(1'b0));

    // Load extraction
    load_case("lb_off3", 3'd2, 2'd3, 32'hFFFF_FF80);
    load_case("lbu_off3", 3'd3, 2'd3, 32'h0000_0080);
    load_case("lh_off2", 3'd4, 2'd2, 32'hFFFF_80FF);
    load_case("lhu_off0", 3'd5, 2'd0, 32'h0000_7F01);
    load_case("lw", 3'd1, 2'd0, 32'h80FF_7F01);

    // Delayed response
    issue(es_bus(1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 5'd4, 32'h2000, 32'hBFC0_0200));
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("dly_stall", 73'(MEM_load_stall), 73'(1'b1));
      chk("dly_allowin", 73'(ms_allowin), 73'(1'b0));
      chk("dly_valid", 73'(ms_to_ws_valid), 73'(1'b0));
      tick();
    end
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1357_9BDF;
    settle();
    chk("dly_result", ms_to_ws_bus, ws_bus(1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h1357_9BDF, 32'hBFC0_0200));
    chk("dly_nostall", 73'(MEM_load_stall), 73'(1'b0));
    tick();
    data_sram_data_ok = 1'b0;

    // Back-pressure: response buffered while WB stalls
    exp_bus = ws_bus(1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 32'hCAFE_F00D, 32'hBFC0_0300);
    issue(es_bus(1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 5'd6, 32'h3004, 32'hBFC0_0300));
    ws_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE_F00D;
    settle();
    chk("bp_valid0", 73'(ms_to_ws_valid), 73'(1'b1));
    chk("bp_allowin0", 73'(ms_allowin), 73'(1'b0));
    chk("bp_bus0", ms_to_ws_bus, exp_bus);
    tick();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
    settle();
    chk("bp_bus1", ms_to_ws_bus, exp_bus);
    chk("bp_allowin1", 73'(ms_allowin), 73'(1'b0));
    tick();
    ws_allowin = 1'b1;
    settle();
    chk("bp_valid2", 73'(ms_to_ws_valid), 73'(1'b1));
    chk("bp_allowin2", 73'(ms_allowin), 73'(1'b1));
    chk("bp_bus2", ms_to_ws_bus, exp_bus);
    tick();
    settle();
    chk("bp_gone", 73'(ms_to_ws_valid), 73'(1'b0));

    // Flush with outstanding load; orphan response must be dropped
    issue(es_bus(1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 5'd3, 32'h4000, 32'hBFC0_0400));
    settle();
    chk("fl_stall", 73'(MEM_load_stall), 73'(1'b1));
    ws_ex = 1'b1;
    tick();
    ws_ex = 1'b0;
    settle();
    chk("fl_valid", 73'(ms_to_ws_valid), 73'(1'b0));
    chk("fl_allowin", 73'(ms_allowin), 73'(1'b1));
    chk("fl_bus", ms_to_ws_bus, '0);
    chk("fl_dest", 73'(MEM_dest), '0);
    issue(es_bus(1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 5'd8, 32'h5001, 32'hBFC0_0500));
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
    settle();
    chk("orphan_drop", 73'(ms_to_ws_valid), 73'(1'b0));
    chk("orphan_stall", 73'(MEM_load_stall), 73'(1'b1));
    tick();
    data_sram_rdata = 32'h0000_8000;
    settle();
    chk("after_fl_lb", ms_to_ws_bus, ws_bus(1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 32'hFFFF_FF80, 32'hBFC0_0500));
    chk("after_fl_valid", 73'(ms_to_ws_valid), 73'(1'b1));
    tick();
    data_sram_data_ok = 1'b0;

    // Flush coinciding with the waiting load's own response: nothing left to discard
    issue(es_bus(1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 5'd3, 32'h4000, 32'hBFC0_0600));
    ws_eret = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5555_5555;
    tick();
    ws_eret = 1'b0; data_sram_data_ok = 1'b0;
    settle();
    chk("flr_valid", 73'(ms_to_ws_valid), 73'(1'b0));
    issue(es_bus(1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 5'd2, 32'h4004, 32'hBFC0_0700));
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_2222;
    settle();
    chk("flr_next_valid", 73'(ms_to_ws_valid), 73'(1'b1));
    chk("flr_next_bus", ms_to_ws_bus, ws_bus(1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h1111_2222, 32'hBFC0_0700));
    tick();
    data_sram_data_ok = 1'b0;

    // Flush in the same cycle as an incoming instruction drops it
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = es_bus(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 5'd7, 32'h77, 32'hBFC0_0800);
    ws_eret = 1'b1;
    tick();
    es_to_ms_valid = 1'b0; es_to_ms_bus = '0; ws_eret = 1'b0;
    settle();
    chk("flin_valid", 73'(ms_to_ws_valid), 73'(1'b0));
    chk("flin_dest", 73'(MEM_dest), '0);

    // Exception flag visible to EXE
    issue(es_bus(1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 5'd2, 32'hAA, 32'hBFC0_0900));
    settle();
    chk("msex", 73'(MS_EX), 73'(1'b1));
    chk("msex_bus", ms_to_ws_bus, ws_bus(1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 32'hAA, 32'hBFC0_0900));
    tick();

    // Synchronous reset mid-wait
    issue(es_bus(1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 5'd1, 32'h6000, 32'hBFC0_0A00));
    settle();
    chk("rw_stall", 73'(MEM_load_stall), 73'(1'b1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("rw_valid", 73'(ms_to_ws_valid), 73'(1'b0));
    chk("rw_allowin", 73'(ms_allowin), 73'(1'b1));
    chk("rw_bus", ms_to_ws_bus, '0);
    chk("rw_dest", 73'(MEM_dest), '0);
    chk("rw_stall0", 73'(MEM_load_stall), '0);
    issue(es_bus(1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 5'd1, 32'h6004, 32'hBFC0_0B00));
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h2468_ACE0;
    settle();
    chk("rw_nodiscard", 73'(ms_to_ws_valid), 73'(1'b1));
    tick();
    data_sram_data_ok = 1'b0;

    // Randomized single-instruction traffic against the reference model
    for (int t = 0; t < 200; t++) begin
      int          op, delay;
      logic        mem, we, bd, done;
      logic [4:0]  dest;
      logic [31:0] alu, pc, rd;
      op    = $urandom_range(0, 6);
      mem   = (op != 0);
      we    = (op == 6) ? 1'b0 : 1'($urandom_range(0, 1));
      bd    = 1'($urandom_range(0, 1));
      dest  = 5'($urandom);
      pc    = $urandom;
      rd    = $urandom;
      alu   = $urandom;
      if (op == 1 || op == 6) alu[1:0] = 2'b00;
      if (op == 4 || op == 5) alu[0] = 1'b0;
      delay = $urandom_range(0, 3);
      settle();
      chk("rnd_allowin", 73'(ms_allowin), 73'(1'b1));
      issue(es_bus(1'b0, bd, 1'b0, 3'(op), mem, we, dest, alu, pc));
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        data_sram_data_ok = mem && (c == delay);
        data_sram_rdata   = data_sram_data_ok ? rd : $urandom;
        ws_allowin        = (c >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
        settle();
        chk("rnd_valid", 73'(ms_to_ws_valid), 73'(!mem || c >= delay));
        chk("rnd_stall", 73'(MEM_load_stall), 73'(mem && we && c < delay));
        chk("rnd_dest", 73'(MEM_dest), 73'(we ? dest : 5'd0));
        if (ms_to_ws_valid && ws_allowin) begin
          chk("rnd_bus", ms_to_ws_bus, ws_bus(1'b0, bd, 1'b0, we, dest, ref_result(op, alu, rd), pc));
          done = 1'b1;
        end
        tick();
      end
      data_sram_data_ok = 1'b0;
      ws_allowin = 1'b1;
      chk("rnd_timeout", 73'(done), 73'(1'b1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
